// File: rtl/two_d_denormalize.sv
// Rescales a sign-magnitude {x,y} direction normalized to length d up to length len.
// Each magnitude is computed as mag*len/d on one shared restoring divider, x first and then y.
// State | meaning
// IDLE  | ready for a request
// MUL   | form both products, trap d==0
// DIV_X | divide px by d, one quotient bit per cycle
// DIV_Y | divide py by d, one quotient bit per cycle
// OUT   | hold the result until out_ready
module two_d_denormalize #(
  parameter int MAG_W = 10,
  parameter int D_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_W-1:0]     d,
  input  logic [MAG_W-1:0]   len,
  input  logic [2*MAG_W+1:0] dir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*MAG_W+1:0] out_dir,
  output logic               out_sat,
  output logic               out_err
);

  localparam int P_W   = 2 * MAG_W;
  localparam int CNT_W = $clog2(P_W);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_X, S_DIV_Y, S_OUT} state_t;

  state_t             r_state;
  logic [D_W-1:0]     r_d;
  logic [MAG_W-1:0]   r_len, r_mx, r_my, r_qx;
  logic               r_sx, r_sy, r_satx;
  logic [P_W-1:0]     r_num, r_py;
  logic [D_W-1:0]     r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready, r_out_valid, r_out_sat, r_out_err;
  logic [2*MAG_W+1:0] r_out_dir;

  logic [D_W:0]       w_rem_sh, w_rem_sub;
  logic               w_ge, w_q_sat, w_sign_y;
  logic [P_W-1:0]     w_q, w_px, w_py;
  logic [MAG_W-1:0]   w_q_mag;

  // r_num shifts the dividend out at the top while quotient bits enter at the bottom
  assign w_rem_sh  = {r_rem, r_num[P_W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_d});
  assign w_rem_sub = w_rem_sh - {1'b0, r_d};
  assign w_q       = {r_num[P_W-2:0], w_ge};
  assign w_q_sat   = |w_q[P_W-1:MAG_W];
  assign w_q_mag   = w_q_sat ? {MAG_W{1'b1}} : w_q[MAG_W-1:0];
  assign w_sign_y  = r_sy & (|w_q_mag);
  assign w_px      = {{MAG_W{1'b0}}, r_mx} * {{MAG_W{1'b0}}, r_len};
  assign w_py      = {{MAG_W{1'b0}}, r_my} * {{MAG_W{1'b0}}, r_len};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_d         <= '0;
      r_len       <= '0;
      r_mx        <= '0;
      r_my        <= '0;
      r_sx        <= 1'b0;
      r_sy        <= 1'b0;
      r_qx        <= '0;
      r_satx      <= 1'b0;
      r_num       <= '0;
      r_py        <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_dir   <= '0;
      r_out_sat   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_d        <= d;
            r_len      <= len;
            r_sx       <= dir[2*MAG_W+1];
            r_mx       <= dir[2*MAG_W:MAG_W+1];
            r_sy       <= dir[MAG_W];
            r_my       <= dir[MAG_W-1:0];
            r_in_ready <= 1'b0;
            r_state    <= S_MUL;
          end
        end
        S_MUL: begin
          r_num <= w_px;
          r_py  <= w_py;
          r_rem <= '0;
          r_cnt <= CNT_W'(P_W - 1);
          if (r_d == '0) begin
            r_out_dir <= '0;
            r_out_sat <= 1'b0;
            r_out_err <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_state <= S_DIV_X;
          end
        end
        S_DIV_X: begin
          if (r_cnt == '0) begin
            r_qx    <= w_q_mag;
            r_satx  <= w_q_sat;
            r_num   <= r_py;
            r_rem   <= '0;
            r_cnt   <= CNT_W'(P_W - 1);
            r_state <= S_DIV_Y;
          end else begin
            r_num <= w_q;
            r_rem <= w_ge ? w_rem_sub[D_W-1:0] : w_rem_sh[D_W-1:0];
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV_Y: begin
          if (r_cnt == '0) begin
            r_out_dir   <= {r_sx & (|r_qx), r_qx, w_sign_y, w_q_mag};
            r_out_sat   <= r_satx | w_q_sat;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_num <= w_q;
            r_rem <= w_ge ? w_rem_sub[D_W-1:0] : w_rem_sh[D_W-1:0];
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_OUT: begin
          // the d==0 path arrives here with out_valid still low and raises it one cycle later
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_dir   = r_out_dir;
  assign out_sat   = r_out_sat;
  assign out_err   = r_out_err;

endmodule
